// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes, ALUOp encodings and funct codes shared by the ID/EX issue stage
//
// Purpose: common constants for the 4-bit-control MIPS ALU and its feed stage.
// Ports:   none (package).
package alu_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_NOR = 4'd12,
        ALU_ILL = 4'd15
    } alu_ctl_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_OR    = 2'b11
    } alu_op_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/alu_ctl_decode.sv
// rtl/alu_ctl_decode.sv - combinational ALUOp/funct to ALU control decoder
//
// Purpose: map main-decoder ALUOp and R-type funct onto the 4-bit ALU control.
// Ports:
//   alu_op  in  2  main-decoder ALUOp
//   funct   in  6  R-type funct field
//   alu_ctl out 4  ALU control code (15 for an undecodable funct)
//   illegal out 1  funct not recognised under ALUOp 10
module alu_ctl_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctl,
    output logic       illegal
);

    always_comb begin
        alu_ctl = ALU_ADD;
        illegal = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_ctl = ALU_ADD;
            ALUOP_SUB: alu_ctl = ALU_SUB;
            ALUOP_OR:  alu_ctl = ALU_OR;
            default: begin
                case (funct)
                    FUNCT_ADD: alu_ctl = ALU_ADD;
                    FUNCT_SUB: alu_ctl = ALU_SUB;
                    FUNCT_AND: alu_ctl = ALU_AND;
                    FUNCT_OR:  alu_ctl = ALU_OR;
                    FUNCT_NOR: alu_ctl = ALU_NOR;
                    FUNCT_SLT: alu_ctl = ALU_SLT;
                    default: begin
                        // Code 15 makes the ALU emit 0; the entry still flows downstream.
                        alu_ctl = ALU_ILL;
                        illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/id_ex_issue.sv
// rtl/id_ex_issue.sv - ID/EX issue stage: ALU control decode, operand select, 2-entry skid buffer
//
// Purpose: registers {alu_ctl, op1, op2, rd} into a 2-entry buffer so the ALU
//          sees only registered values.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          upstream handshake (in_ready is registered)
//   alu_op, funct, alu_src     decode inputs
//   rs_val, rt_val, imm, rd_in operand and destination inputs
//   flush                      drop all held and incoming entries
//   out_valid/out_ready        downstream handshake
//   alu_ctl, op1, op2, rd_out, illegal   head entry fields
//   stall_cnt                  saturating count of back-pressure cycles
module id_ex_issue
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int RD_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic             alu_src,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [WIDTH-1:0] imm,
    input  logic [RD_W-1:0]  rd_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_ctl,
    output logic [WIDTH-1:0] op1,
    output logic [WIDTH-1:0] op2,
    output logic [RD_W-1:0]  rd_out,
    output logic             illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [3:0]       in_ctl;
    logic             in_ill;
    logic [WIDTH-1:0] in_op2;

    alu_ctl_decode u_decode (
        .alu_op  (alu_op),
        .funct   (funct),
        .alu_ctl (in_ctl),
        .illegal (in_ill)
    );

    assign in_op2 = alu_src ? imm : rt_val;

    logic [1:0]       count_q, count_n;
    logic             in_ready_q;
    logic [CNT_W-1:0] stall_q;

    logic [3:0]       head_ctl, tail_ctl;
    logic             head_ill, tail_ill;
    logic [WIDTH-1:0] head_op1, tail_op1;
    logic [WIDTH-1:0] head_op2, tail_op2;
    logic [RD_W-1:0]  head_rd,  tail_rd;

    logic accept, pop;
    logic load_head_in, load_head_tail, load_tail_in;

    assign out_valid = (count_q != 2'd0);
    assign accept    = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    // Head takes the new entry when it is the only one left after this edge;
    // otherwise a pop from full promotes the tail.
    assign load_head_in   = accept && ((count_q == 2'd0) || (count_q == 2'd1 && pop));
    assign load_head_tail = pop && (count_q == 2'd2);
    assign load_tail_in   = accept && (count_q == 2'd1) && !pop;

    always_comb begin
        count_n = count_q;
        if (flush) begin
            count_n = 2'd0;
        end else if (accept && !pop) begin
            count_n = count_q + 2'd1;
        end else if (pop && !accept) begin
            count_n = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
            stall_q    <= '0;
            head_ctl   <= 4'd0;
            head_ill   <= 1'b0;
            head_op1   <= '0;
            head_op2   <= '0;
            head_rd    <= '0;
            tail_ctl   <= 4'd0;
            tail_ill   <= 1'b0;
            tail_op1   <= '0;
            tail_op2   <= '0;
            tail_rd    <= '0;
        end else begin
            count_q    <= count_n;
            in_ready_q <= (count_n != 2'd2);
            // Survives flush on purpose: it measures downstream back-pressure.
            if (out_valid && !out_ready && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (!flush) begin
                if (load_head_in) begin
                    head_ctl <= in_ctl;
                    head_ill <= in_ill;
                    head_op1 <= rs_val;
                    head_op2 <= in_op2;
                    head_rd  <= rd_in;
                end else if (load_head_tail) begin
                    head_ctl <= tail_ctl;
                    head_ill <= tail_ill;
                    head_op1 <= tail_op1;
                    head_op2 <= tail_op2;
                    head_rd  <= tail_rd;
                end
                if (load_tail_in) begin
                    tail_ctl <= in_ctl;
                    tail_ill <= in_ill;
                    tail_op1 <= rs_val;
                    tail_op2 <= in_op2;
                    tail_rd  <= rd_in;
                end
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign alu_ctl   = head_ctl;
    assign illegal   = head_ill;
    assign op1       = head_op1;
    assign op2       = head_op2;
    assign rd_out    = head_rd;
    assign stall_cnt = stall_q;

endmodule

// File: doc/id_ex_issue.md
Name: id_ex_issue

Overview:
Upstream feed stage for the 4-bit-control MIPS ALU. It accepts decoded instruction fields from the ID stage, derives the ALU control code and selects the second operand. It registers {ALUctl, op1, op2, rd} into a 2-entry skid buffer with valid/ready handshakes on both sides. Its outputs drive the ALU inputs directly, so the ALU sees only registered values.

Parameters:
WIDTH, 32, datapath width of op1/op2/rs_val/rt_val/imm
RD_W, 5, destination register index width
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ID stage presents an instruction
in_ready  out  1  stage can accept this cycle
alu_op  in  2  main-decoder ALUOp
funct  in  6  R-type funct field
alu_src  in  1  1: op2 = imm, 0: op2 = rt_val
rs_val  in  WIDTH  register rs value
rt_val  in  WIDTH  register rt value
imm  in  WIDTH  sign-extended immediate
rd_in  in  RD_W  destination register index
flush  in  1  discard all held and incoming entries
out_valid  out  1  head entry valid
out_ready  in  1  downstream (EX/MEM) accepts head
alu_ctl  out  4  ALU control code of head
op1  out  WIDTH  = rs_val of head
op2  out  WIDTH  selected second operand of head
rd_out  out  RD_W  destination of head
illegal  out  1  head carries an undecodable funct
stall_cnt  out  CNT_W  saturating count of back-pressure cycles

Behaviour:
- Reset (async, rst_n=0): buffer empty, out_valid=0, in_ready=1 once rst_n releases, alu_ctl=0, op1=op2=0, rd_out=0, illegal=0, stall_cnt=0. Reset mid-transfer drops all entries.
- Control decode, combinational on input:
  - ALUOp 00 -> 2 (add)
  - ALUOp 01 -> 6 (sub)
  - ALUOp 11 -> 1 (or)
  - ALUOp 10 -> funct: 100000->2, 100010->6, 100100->0, 100101->1, 100111->12, 101010->7
  - any other funct -> alu_ctl=15, illegal=1. Code 15 makes the ALU output 0; the entry still flows.
- op2 = alu_src ? imm : rt_val. op1 = rs_val. No arithmetic in this block.
- Storage: 2-entry buffer, head/tail. Outputs come from the head register only, so latency is 1 cycle from accept to out_valid.
- Handshakes:
  - Accept when in_valid & in_ready.
  - Pop when out_valid & out_ready.
  - in_ready = (count<2), registered. It must not depend combinationally on out_ready.
  - Simultaneous accept and pop at count=1 or 2: count unchanged, FIFO order kept.
  - Full (count=2): in_ready=0. in_valid is ignored.
  - Empty: out_valid=0. Output fields hold their last values and are don't-care.
- Flush: next edge count=0 and out_valid=0. An input accepted in the flush cycle is dropped. A pop in the same cycle is still counted as a transfer by downstream. flush has priority over accept.
- stall_cnt increments each cycle with out_valid & !out_ready. It saturates at all-ones and is not cleared by flush.
- While out_valid=1 and out_ready=0, head fields are stable.

Decomposition:
- Package alu_pkg: ALUctl constants (AND=0, OR=1, ADD=2, SUB=6, SLT=7, NOR=12, ILL=15), ALUOp encodings, funct codes, WIDTH default.
- Sub-module alu_ctl_decode (combinational: alu_op, funct -> alu_ctl, illegal), reusable by the ALU testbench.
- Skid buffer logic stays inline.

Test Plan:
1. Reset, then alu_op=10, funct=100010, rs=9, rt=4, alu_src=0, out_ready=1 -> next cycle out_valid=1, alu_ctl=6, op1=9, op2=4.
2. alu_op=00, alu_src=1, imm=0xFFFFFFFC, rs=16 -> alu_ctl=2, op2=0xFFFFFFFC.
3. out_ready=0, three back-to-back inputs A, B, C -> A and B accepted, in_ready=0 on the C cycle, stall_cnt counts up. Then out_ready=1 -> A then B popped in order, C accepted after in_ready rises.
4. funct=001000 with alu_op=10 -> alu_ctl=15, illegal=1, entry delivered normally.
5. Full buffer plus flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input never appears.
6. Assert rst_n=0 mid-stream while full -> out_valid=0 and stall_cnt=0 immediately, without waiting for a clock edge.
